cim_unit: RTL

Compute-in-memory responder that sits on the far side of the core's CIM port and consumes its `write`, `cim`, `partial_sum`, `reset_output`, `output_reg`, `address` and `input_data` strobes. It holds a 32-bit weight array and a bank of accumulating output registers. Multi-cycle dot-product commands stall the core through its `HLT` input. Array reads and register reads are returned on `cim_output` in the same cycle.

---
 rtl/cim_pkg.sv | 37 +++
 rtl/cim_if.sv | 23 ++
 rtl/cim_dot4.sv | 25 ++
 rtl/cim_unit.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/cim_pkg.sv
// Shared types and constants for the compute-in-memory responder.
package cim_pkg;

    localparam int LANE_W = 8;   // bits per signed weight/activation lane
    localparam int LANES  = 4;   // lanes per 32-bit word
    localparam int DOT_W  = 18;  // width of one 4-lane dot product

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        CMD_WR   = 3'd0,
        CMD_COMP = 3'd1,
        CMD_RST  = 3'd2,
        CMD_RREG = 3'd3,
        CMD_MRD  = 3'd4
    } cmd_e;

    // Strobe priority: write beats any CIM command, compute beats register clear.
    function automatic cmd_e decode_cmd(input logic wr, input logic cim,
                                        input logic psum, input logic rst_out);
        if (wr)
            return CMD_WR;
        else if (cim && psum)
            return CMD_COMP;
        else if (cim && rst_out)
            return CMD_RST;
        else if (cim)
            return CMD_RREG;
        else
            return CMD_MRD;
    endfunction

endpackage

// File: rtl/cim_if.sv
// Core-to-CIM port: command strobes from the core, read data and stall back.
interface cim_if;
    logic        write;
    logic        cim;
    logic        partial_sum;
    logic        reset_output;
    logic [3:0]  output_reg;
    logic [31:0] address;
    logic [31:0] input_data;
    logic [31:0] cim_output;
    logic        hlt_req;
    logic        busy;

    modport master (
        output write, cim, partial_sum, reset_output, output_reg, address, input_data,
        input  cim_output, hlt_req, busy
    );

    modport slave (
        input  write, cim, partial_sum, reset_output, output_reg, address, input_data,
        output cim_output, hlt_req, busy
    );
endinterface

// File: rtl/cim_dot4.sv
// Combinational signed 4-lane multiply-add of activations against one weight word.
module cim_dot4
    import cim_pkg::*;
(
    input  logic [31:0]      act,
    input  logic [31:0]      wgt,
    output logic [DOT_W-1:0] sum
);

    logic signed [2*LANE_W-1:0] prod;
    logic signed [DOT_W-1:0]    acc;

    // Sum the sign-extended per-lane products; 18 bits cannot overflow for 4 lanes.
    always_comb begin
        prod = '0;
        acc  = '0;
        for (int i = 0; i < LANES; i++) begin
            prod = $signed(act[i*LANE_W +: LANE_W]) * $signed(wgt[i*LANE_W +: LANE_W]);
            acc  = acc + {{(DOT_W-2*LANE_W){prod[2*LANE_W-1]}}, prod};
        end
    end

    assign sum = acc;

endmodule

// File: rtl/cim_unit.sv
// Compute-in-memory responder: weight array, accumulating output registers,
// and a column-serial dot-product engine that stalls the core while it runs.
//
//   state | meaning
//   IDLE  | decode one command per cycle; COMP starts a compute and stalls
//   BUSY  | accumulate column col into out_reg[col], one column per cycle
//   DONE  | release the stall so the core retires COMP; held COMP ignored
module cim_unit
    import cim_pkg::*;
#(
    parameter int AW   = 8,
    parameter int NCOL = 16,
    parameter int ACCW = 32
) (
    input  logic CLK,
    input  logic RES,
    cim_if.slave bus
);

    localparam logic [3:0] COL_LAST = 4'(NCOL - 1);

    cmd_e             cmd;
    state_e           state_q, state_d;
    logic [3:0]       col_q, col_d;
    logic             hlt;
    logic             busy_q;
    logic [31:0]      act_q;
    logic [AW-1:0]    base_q;
    logic [AW-1:0]    addr;
    logic [AW-1:0]    col_addr;
    logic [31:0]      mem [2**AW];
    logic [ACCW-1:0]  out_reg [NCOL];
    logic [DOT_W-1:0] dot_sum;
    logic [ACCW-1:0]  dot_ext;
    logic [31:0]      rd_data;
    logic             unused_addr_hi;

    assign cmd            = decode_cmd(bus.write, bus.cim, bus.partial_sum, bus.reset_output);
    assign addr           = bus.address[AW-1:0];
    assign unused_addr_hi = ^bus.address[31:AW];
    assign col_addr       = base_q + AW'(col_q);

    // State and column counter register.
    always_ff @(posedge CLK) begin
        if (RES) begin
            state_q <= ST_IDLE;
            col_q   <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
        end
    end

    // Next state, column advance and stall request.
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        hlt     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd == CMD_COMP) begin
                    state_d = ST_BUSY;
                    col_d   = '0;
                    hlt     = 1'b1;
                end
            end
            ST_BUSY: begin
                hlt = 1'b1;
                if (col_q == COL_LAST)
                    state_d = ST_DONE;
                else
                    col_d = col_q + 4'd1;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                col_d   = '0;
            end
            default: begin
                state_d = ST_IDLE;
                col_d   = '0;
            end
        endcase
    end

    // Registered busy flag tracks entry into BUSY.
    always_ff @(posedge CLK) begin
        if (RES)
            busy_q <= 1'b0;
        else
            busy_q <= (state_d == ST_BUSY);
    end

    // Capture activations and base address when a compute is accepted.
    always_ff @(posedge CLK) begin
        if (RES) begin
            act_q  <= '0;
            base_q <= '0;
        end else if (state_q == ST_IDLE && cmd == CMD_COMP) begin
            act_q  <= bus.input_data;
            base_q <= addr;
        end
    end

    // Weight array write port; contents survive reset.
    always_ff @(posedge CLK) begin
        if (state_q == ST_IDLE && cmd == CMD_WR)
            mem[addr] <= bus.input_data;
    end

    cim_dot4 u_dot4 (
        .act (act_q),
        .wgt (mem[col_addr]),
        .sum (dot_sum)
    );

    assign dot_ext = {{(ACCW-DOT_W){dot_sum[DOT_W-1]}}, dot_sum};

    // Output registers: cleared by reset or RST, accumulated one column per BUSY cycle.
    always_ff @(posedge CLK) begin
        if (RES) begin
            for (int c = 0; c < NCOL; c++)
                out_reg[c] <= '0;
        end else if (state_q == ST_IDLE && cmd == CMD_RST) begin
            for (int c = 0; c < NCOL; c++)
                out_reg[c] <= '0;
        end else if (state_q == ST_BUSY) begin
            out_reg[col_q] <= out_reg[col_q] + dot_ext;
        end
    end

    // Same-cycle read mux; stalled cycles return zero.
    always_comb begin
        rd_data = '0;
        if (state_q == ST_IDLE) begin
            case (cmd)
                CMD_WR, CMD_MRD: rd_data = mem[addr];
                CMD_RREG: begin
                    if (int'(bus.output_reg) < NCOL)
                        rd_data = 32'(out_reg[bus.output_reg]);
                end
                default: rd_data = '0;
            endcase
        end
    end

    assign bus.cim_output = rd_data;
    assign bus.hlt_req    = hlt;
    assign bus.busy       = busy_q;

endmodule
